// File: rtl/apb_master_bridge_if.sv
// Core request/response and APB master signal bundle for apb_master_bridge.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] M_PADDR;
    logic                  M_PWRITE;
    logic                  M_PSELx;
    logic                  M_PENABLE;
    logic [DATA_WIDTH-1:0] M_PWDATA;
    logic [DATA_WIDTH-1:0] M_PRDATA;
    logic                  M_PREADY;

    // Bridge view: accepts core requests, drives the APB master port.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );

    // Environment view: the core plus the interconnect slave side.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding core request to APB SETUP/ACCESS transfer, with ACCESS timeout.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    apb_master_bridge_if.master bus
);
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_ready;
    logic                  r_rsp_valid;
    logic                  r_psel;
    logic                  r_penable;

    // Transfer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr;
                        r_write <= bus.req_write;
                        r_wdata <= bus.req_wdata;
                        r_ready <= 1'b0;
                        r_psel  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_count   <= '0;
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY takes priority over a timeout on the same cycle.
                    if (bus.M_PREADY) begin
                        r_rdata     <= r_write ? '0 : bus.M_PRDATA;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (TO_EN && (r_count == TO_LAST)) begin
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_count <= CNT_W'(r_count + CNT_W'(1));
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.M_PADDR   = r_addr;
    assign bus.M_PWRITE  = r_write;
    assign bus.M_PSELx   = r_psel;
    assign bus.M_PENABLE = r_penable;
    assign bus.M_PWDATA  = r_wdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed transfers, monitor checks responses.
module tb_apb_master_bridge;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    rsp_t exp_q[$];

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] prdata, input int waits, input bit to, input bit robust);
        int   n_acc;
        rsp_t e;
        n_acc = to ? int'(TO) : waits + 1;
        check("idle_ready", 32'(bus.req_ready), 32'd1);
        check("idle_psel", 32'(bus.M_PSELx), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.M_PRDATA  = prdata;
        bus.M_PREADY  = 1'b0;
        e.rdata = (wr || to) ? '0 : prdata;
        e.err   = to;
        exp_q.push_back(e);
        step();
        check("setup_psel", 32'(bus.M_PSELx), 32'd1);
        check("setup_penable", 32'(bus.M_PENABLE), 32'd0);
        check("setup_ready", 32'(bus.req_ready), 32'd0);
        check("setup_paddr", 32'(bus.M_PADDR), 32'(addr));
        check("setup_pwrite", 32'(bus.M_PWRITE), 32'(wr));
        check("setup_pwdata", 32'(bus.M_PWDATA), 32'(wdata));
        if (robust) begin
            bus.req_addr  = 16'hFFFF;
            bus.req_wdata = ~wdata;
            bus.req_write = ~wr;
            bus.M_PREADY  = 1'b1;
        end else begin
            bus.req_valid = 1'b0;
        end
        for (int i = 0; i < n_acc; i++) begin
            step();
            check("access_psel", 32'(bus.M_PSELx), 32'd1);
            check("access_penable", 32'(bus.M_PENABLE), 32'd1);
            check("access_ready", 32'(bus.req_ready), 32'd0);
            check("access_paddr", 32'(bus.M_PADDR), 32'(addr));
            check("access_pwrite", 32'(bus.M_PWRITE), 32'(wr));
            check("access_pwdata", 32'(bus.M_PWDATA), 32'(wdata));
            bus.M_PREADY = (!to && i == waits);
        end
        step();
        check("resp_psel", 32'(bus.M_PSELx), 32'd0);
        check("resp_penable", 32'(bus.M_PENABLE), 32'd0);
        check("resp_ready", 32'(bus.req_ready), 32'd0);
        bus.M_PREADY  = 1'b0;
        bus.req_valid = 1'b0;
        step();
        check("post_ready", 32'(bus.req_ready), 32'd1);
        check("post_psel", 32'(bus.M_PSELx), 32'd0);
        check("post_paddr_held", 32'(bus.M_PADDR), 32'(addr));
    endtask

    // Monitor: every rsp_valid cycle must match the oldest expected response.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.M_PRDATA  = '0;
        bus.M_PREADY  = 1'b0;
        step();
        step();
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_psel", 32'(bus.M_PSELx), 32'd0);
        check("rst_penable", 32'(bus.M_PENABLE), 32'd0);
        check("rst_paddr", 32'(bus.M_PADDR), 32'd0);
        check("rst_pwrite", 32'(bus.M_PWRITE), 32'd0);
        check("rst_pwdata", 32'(bus.M_PWDATA), 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b0;
        step();

        // zero-wait read, then back-to-back write with 3 wait states
        xfer(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0);
        xfer(1'b1, 16'h0040, 16'h1234, 16'h5555, 3, 1'b0, 1'b0);
        // timeout with PREADY held low
        xfer(1'b0, 16'h0100, 16'h0000, 16'h7777, 0, 1'b1, 1'b0);
        // PREADY on the final timeout cycle wins
        xfer(1'b0, 16'h0200, 16'h0000, 16'h00A5, 3, 1'b0, 1'b0);
        // PREADY in SETUP and request changes after acceptance are ignored
        xfer(1'b0, 16'h0300, 16'h0000, 16'h0F0F, 1, 1'b0, 1'b1);
        xfer(1'b1, 16'h0302, 16'hA5A5, 16'h0F0F, 0, 1'b0, 1'b1);

        // reset mid-ACCESS: bus drops at once, no response
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0400;
        bus.M_PRDATA  = 16'hDEAD;
        bus.M_PREADY  = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        check("pre_rst_penable", 32'(bus.M_PENABLE), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_psel", 32'(bus.M_PSELx), 32'd0);
        check("midrst_penable", 32'(bus.M_PENABLE), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_paddr", 32'(bus.M_PADDR), 32'd0);
        step();
        reset = 1'b0;
        step();
        xfer(1'b0, 16'h0500, 16'h0000, 16'h1357, 2, 1'b0, 1'b0);

        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Upstream stage of the APB interconnect. Converts one vmicro16 core's single-outstanding load/store request into a compliant APB SETUP/ACCESS transfer, drives one master port of the interconnect, and returns read data plus a timeout error to the core. One instance per core; arbitration wait inside the interconnect appears to this block as PREADY wait states.

Parameters:
ADDR_WIDTH, 16, width of req_addr / M_PADDR
DATA_WIDTH, 16, width of write/read data
TIMEOUT, 255, max ACCESS-phase cycles before abort with error; 0 = never time out (internal counter width fixed at 16 bits; TIMEOUT must be < 65536)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core request present; core holds until accepted
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  store data
req_ready  out  1  bridge can accept (IDLE only)
rsp_valid  out  1  one-cycle pulse: transfer complete
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors), held until next response
rsp_err  out  1  1 = timed out, held until next response
M_PADDR  out  ADDR_WIDTH  APB address
M_PWRITE  out  1  APB write
M_PSELx  out  1  APB select (arbiter request)
M_PENABLE  out  1  APB enable
M_PWDATA  out  DATA_WIDTH  APB write data
M_PRDATA  in  DATA_WIDTH  APB read data from interconnect
M_PREADY  in  1  APB ready from interconnect

Behaviour:
- Clock clk; reset asynchronous active-high: state=IDLE, all outputs 0 except req_ready=1; counter=0; latched addr/write/wdata=0.
- FSM states IDLE, SETUP, ACCESS, RESP; all outputs decoded from state or registers (no combinational path from req_* or M_* to outputs).
- IDLE: req_ready=1, PSEL=0, PENABLE=0. If req_valid at clock edge: latch req_addr/req_write/req_wdata, -> SETUP. Else stay.
- SETUP: PSEL=1, PENABLE=0, req_ready=0; exactly one cycle; M_PREADY ignored; counter cleared; -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Each cycle: if M_PREADY=1 -> RESP, rsp_rdata <= write ? 0 : M_PRDATA, rsp_err <= 0. Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP, rsp_rdata <= 0, rsp_err <= 1. Else counter++ and stay.
- PREADY and timeout in the same cycle: PREADY wins (err=0, data captured).
- RESP: rsp_valid=1, PSEL=0, PENABLE=0, req_ready=0; one cycle; -> IDLE.
- M_PADDR/M_PWRITE/M_PWDATA driven from latched registers, stable from SETUP through ACCESS and held afterwards; req_* changes after acceptance have no bus effect.
- Latency: accept edge at cycle 0 -> PSEL cycle 1, PENABLE cycle 2, zero-wait PREADY cycle 2 -> rsp_valid cycle 3, req_ready again cycle 4. Min 4 cycles per transfer; each wait state adds 1.
- Timeout counts ACCESS cycles only; with TIMEOUT=N an unanswered transfer spends exactly N cycles in ACCESS.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async), no rsp_valid issued, transfer lost.
- req_valid while req_ready=0: ignored, no queueing.

Test Plan:
- Zero-wait read: req addr 0x0012 at cycle 0, M_PREADY=1 with M_PRDATA=0xBEEF in cycle 2 -> PSEL cycles 1-2, PENABLE cycle 2, rsp_valid cycle 3, rsp_rdata=0xBEEF, rsp_err=0.
- Write, 3 wait states: addr 0x0040 wdata 0x1234, PREADY in 4th ACCESS cycle -> M_PWDATA=0x1234 and M_PWRITE=1 stable all 5 PSEL cycles, rsp_valid once, rsp_rdata=0.
- Timeout, TIMEOUT=4, M_PREADY held 0 -> exactly 4 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0, PSEL deasserted in RESP.
- PREADY on final timeout cycle (TIMEOUT=4, PREADY in 4th ACCESS cycle, PRDATA=0x00A5) -> rsp_err=0, rsp_rdata=0x00A5.
- Reset asserted mid-ACCESS -> PSEL/PENABLE 0 same cycle, no rsp_valid, req_ready=1 after release; next request completes normally.
- Robustness: M_PREADY=1 during SETUP and req_addr changed to 0xFFFF after acceptance -> transfer still takes full SETUP+ACCESS, M_PADDR keeps original value, back-to-back requests accepted only in IDLE (4-cycle spacing).
